// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: bus master issuing one RAM word read/write per request, with wait states.
// Define MEM_ADDR_CHECK_EN to reject addresses outside ADDRESS_MASK with a fault pulse.
module mem_bus_initiator #(
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [16:0] ADDRESS_MASK = 17'h7f
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         we_req,
  input  logic [15:31] addr_in,
  input  logic [0:31]  wdata,
  output logic         busy,
  output logic         done,
  output logic [0:31]  rdata,
  output logic         fault,
  output logic [15:31] mem_address,
  output logic         mem_write_en,
  output logic [0:31]  mem_data_out,
  input  logic [0:31]  mem_data_in
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FLT
  } state_e;

  localparam logic [3:0] WaitLd = 4'(WAIT_STATES);

`ifdef MEM_ADDR_CHECK_EN
  localparam bit AddrCheck = 1'b1;
`else
  localparam bit AddrCheck = 1'b0;
`endif

  state_e        state_q;
  logic [3:0]    count_q;
  logic [15:31]  addr_q;
  logic [0:31]   wdata_q;
  logic          we_q;
  logic          done_q;
  logic          fault_q;
  logic [0:31]   rdata_q;
  logic          oob;
  logic          in_access;

  assign oob = AddrCheck &&
               ((addr_in & ~ADDRESS_MASK) != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr_in;
            wdata_q <= wdata;
            we_q    <= we_req;
            count_q <= WaitLd;
            if (oob) begin
              state_q <= FLT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
          end else begin
            if (!we_q) begin
              rdata_q <= mem_data_in;
            end
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        FLT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode from registers only, so reset clears them without a clock.
  assign in_access    = (state_q == ACCESS);
  assign busy         = (state_q != IDLE);
  assign mem_address  = in_access ? addr_q : '0;
  assign mem_data_out = in_access ? wdata_q : '0;
  assign mem_write_en = in_access && we_q &&
                        (count_q == 4'd0);
  assign done         = done_q;
  assign fault        = fault_q;
  assign rdata        = rdata_q;

endmodule
